axi4_lite_master: RTL
=====================

Name:
axi4_lite_master

Overview:
AXI4-Lite master core that lets user logic issue single 32-bit register reads and writes through a simple AMCI (AXI Master Control Interface) pulse/idle handshake. It is the counterpart of the ASHI-based slave core and can drive any AXI4-Lite slave directly or through an interconnect. Read and write engines are independent and may run concurrently.

Parameters:
ADDR_WIDTH, 32, width of AMCI_WADDR/AMCI_RADDR and M_AXI_AWADDR/M_AXI_ARADDR

Ports:
clk  in  1  system clock, all logic on rising edge
resetn  in  1  asynchronous active-low reset
AMCI_WADDR  in  ADDR_WIDTH  write byte address, sampled when AMCI_WRITE=1
AMCI_WDATA  in  32  write data, sampled when AMCI_WRITE=1
AMCI_WRITE  in  1  single-cycle write request strobe
AMCI_WRESP  out  2  BRESP of last completed write
AMCI_WIDLE  out  1  1 = write engine idle, ready for a request
AMCI_RADDR  in  ADDR_WIDTH  read byte address, sampled when AMCI_READ=1
AMCI_READ  in  1  single-cycle read request strobe
AMCI_RDATA  out  32  RDATA of last completed read
AMCI_RRESP  out  2  RRESP of last completed read
AMCI_RIDLE  out  1  1 = read engine idle, ready for a request
M_AXI_AWADDR  out  ADDR_WIDTH  write address
M_AXI_AWVALID  out  1  write address valid
M_AXI_AWREADY  in  1  write address ready
M_AXI_WDATA  out  32  write data
M_AXI_WSTRB  out  4  byte strobes, constant 4'hF
M_AXI_WVALID  out  1  write data valid
M_AXI_WREADY  in  1  write data ready
M_AXI_BRESP  in  2  write response
M_AXI_BVALID  in  1  write response valid
M_AXI_BREADY  out  1  write response ready
M_AXI_ARADDR  out  ADDR_WIDTH  read address
M_AXI_ARVALID  out  1  read address valid
M_AXI_ARREADY  in  1  read address ready
M_AXI_RDATA  in  32  read data
M_AXI_RRESP  in  2  read response
M_AXI_RVALID  in  1  read data valid
M_AXI_RREADY  out  1  read data ready

Behaviour:
- Reset (async, resetn=0): both FSMs go to IDLE; all AXI VALID/READY outputs, AWADDR, WDATA, ARADDR, AMCI_RDATA, AMCI_WRESP and AMCI_RRESP clear to 0 immediately. Reset mid-transaction abandons it, and no AMCI response is produced. AxPROT is not provided, so the interconnect defaults it to 0.
- AMCI_WIDLE = (wstate==IDLE) && !AMCI_WRITE. AMCI_RIDLE = (rstate==IDLE) && !AMCI_READ. Both are combinational.
- Write FSM, states W_IDLE -> W_ADDR_DATA -> W_RESP -> W_IDLE:
  - W_IDLE, AMCI_WRITE=1: latch address and data onto AWADDR/WDATA; AWVALID=WVALID=1 from the next cycle.
  - W_ADDR_DATA: each VALID drops the cycle after its own handshake. Addresses and data stay stable while VALID=1. Handshakes may occur in either order or in the same cycle. Once both are complete, go to W_RESP with BREADY=1.
  - W_RESP: on BVALID&&BREADY, capture AMCI_WRESP<=BRESP, set BREADY<=0 and return to W_IDLE.
- Read FSM, states R_IDLE -> R_ADDR -> R_DATA -> R_IDLE:
  - R_IDLE, AMCI_READ=1: latch ARADDR; ARVALID=1 from the next cycle.
  - R_ADDR: on ARREADY, drop ARVALID, set RREADY=1 and go to R_DATA.
  - R_DATA: on RVALID, capture AMCI_RDATA/AMCI_RRESP, set RREADY<=0 and return to R_IDLE.
- Latency: AMCI response registers are valid on the cycle the matching IDLE signal rises. With always-ready slaves, the earliest B/R acceptance is 2 cycles after the strobe.
- A strobe seen while its engine is not in IDLE is ignored, with no queuing.
- Same-cycle AMCI_WRITE and AMCI_READ are both accepted. Response registers hold their value until the next completion.

Optional Feature:
AXI4_LITE_MASTER_SERIAL_AW_W_EN: when defined, WVALID is asserted only on the cycle after the AW handshake, for slaves that need address before data. When undefined, AWVALID and WVALID assert together, as described above.

Decomposition:
- Package axi4_lite_pkg holds:
  - response codes OKAY=2'b00, EXOKAY=2'b01, SLVERR=2'b10, DECERR=2'b11
  - write and read FSM state encodings
- No sub-module. The two small independent FSMs live in one file.

Test Plan:
1. Write 0x0000_0004/0x1234_5678, slave always ready, BRESP=OKAY -> one AW and one W handshake with those values, WSTRB=F, AMCI_WRESP=0, AMCI_WIDLE returns to 1.
2. Same write with AWREADY delayed 5 cycles and WREADY immediate -> WVALID drops after 1 handshake, AWVALID/AWADDR held stable for 5 cycles, exactly one B accepted.
3. Read 0x8, slave returns 0xDEADBEEF with RRESP=DECERR -> AMCI_RDATA=0xDEADBEEF, AMCI_RRESP=3, AMCI_RIDLE rises the cycle after the R handshake.
4. Simultaneous AMCI_WRITE and AMCI_READ, then AMCI_WRITE re-pulsed while busy -> both transactions complete independently, the second write is ignored, and only one AW is issued.
5. resetn pulsed low while BREADY=1 -> all VALID/READY outputs drop immediately, both IDLEs are 1 after release, and a late BVALID is ignored.
6. With AXI4_LITE_MASTER_SERIAL_AW_W_EN defined -> WVALID first rises the cycle after the AW handshake, and the final response is unchanged.

Source files
------------

// File: rtl/axi4_lite_master_pkg.sv
// Response codes and FSM state types shared by the AXI4-Lite master core.
package axi4_lite_pkg;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] EXOKAY = 2'b01;
  localparam logic [1:0] SLVERR = 2'b10;
  localparam logic [1:0] DECERR = 2'b11;

  typedef enum logic [1:0] {
    W_IDLE,
    W_ADDR_DATA,
    W_RESP
  } wstate_t;

  typedef enum logic [1:0] {
    R_IDLE,
    R_ADDR,
    R_DATA
  } rstate_t;

endpackage

// File: rtl/axi4_lite_master_if.sv
// AXI4-Lite bus (AW/W/B/AR/R channels) between the master core and a slave or interconnect.
interface axi4_lite_master_if #(
  parameter int unsigned ADDR_WIDTH = 32
);

  logic [ADDR_WIDTH-1:0] M_AXI_AWADDR;
  logic                  M_AXI_AWVALID;
  logic                  M_AXI_AWREADY;
  logic [31:0]           M_AXI_WDATA;
  logic [3:0]            M_AXI_WSTRB;
  logic                  M_AXI_WVALID;
  logic                  M_AXI_WREADY;
  logic [1:0]            M_AXI_BRESP;
  logic                  M_AXI_BVALID;
  logic                  M_AXI_BREADY;
  logic [ADDR_WIDTH-1:0] M_AXI_ARADDR;
  logic                  M_AXI_ARVALID;
  logic                  M_AXI_ARREADY;
  logic [31:0]           M_AXI_RDATA;
  logic [1:0]            M_AXI_RRESP;
  logic                  M_AXI_RVALID;
  logic                  M_AXI_RREADY;

  modport master (
    output M_AXI_AWADDR, M_AXI_AWVALID, M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WVALID,
    output M_AXI_BREADY, M_AXI_ARADDR, M_AXI_ARVALID, M_AXI_RREADY,
    input  M_AXI_AWREADY, M_AXI_WREADY, M_AXI_BRESP, M_AXI_BVALID,
    input  M_AXI_ARREADY, M_AXI_RDATA, M_AXI_RRESP, M_AXI_RVALID
  );

  modport slave (
    input  M_AXI_AWADDR, M_AXI_AWVALID, M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WVALID,
    input  M_AXI_BREADY, M_AXI_ARADDR, M_AXI_ARVALID, M_AXI_RREADY,
    output M_AXI_AWREADY, M_AXI_WREADY, M_AXI_BRESP, M_AXI_BVALID,
    output M_AXI_ARREADY, M_AXI_RDATA, M_AXI_RRESP, M_AXI_RVALID
  );

endinterface

// File: rtl/axi4_lite_master.sv
// AXI4-Lite master: independent single-beat write and read engines driven by AMCI strobes.
// Optional AXI4_LITE_MASTER_SERIAL_AW_W_EN presents W only after the AW handshake.
module axi4_lite_master
  import axi4_lite_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  resetn,

  input  logic [ADDR_WIDTH-1:0] AMCI_WADDR,
  input  logic [31:0]           AMCI_WDATA,
  input  logic                  AMCI_WRITE,
  output logic [1:0]            AMCI_WRESP,
  output logic                  AMCI_WIDLE,

  input  logic [ADDR_WIDTH-1:0] AMCI_RADDR,
  input  logic                  AMCI_READ,
  output logic [31:0]           AMCI_RDATA,
  output logic [1:0]            AMCI_RRESP,
  output logic                  AMCI_RIDLE,

  axi4_lite_master_if.master    m_axi
);

  wstate_t               r_wstate;
  logic                  r_awvalid;
  logic                  r_wvalid;
  logic                  r_bready;
  logic                  r_aw_done;
  logic                  r_w_done;
  logic [ADDR_WIDTH-1:0] r_awaddr;
  logic [31:0]           r_wdata;
  logic [1:0]            r_wresp;

  rstate_t               r_rstate;
  logic                  r_arvalid;
  logic                  r_rready;
  logic [ADDR_WIDTH-1:0] r_araddr;
  logic [31:0]           r_rdata;
  logic [1:0]            r_rresp;

  logic w_aw_hs;
  logic w_w_hs;
  logic w_aw_fin;
  logic w_w_fin;

  assign w_aw_hs  = r_awvalid && m_axi.M_AXI_AWREADY;
  assign w_w_hs   = r_wvalid  && m_axi.M_AXI_WREADY;
  // A channel counts as finished if it completed earlier or completes this cycle.
  assign w_aw_fin = r_aw_done || w_aw_hs;
  assign w_w_fin  = r_w_done  || w_w_hs;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_wstate  <= W_IDLE;
      r_awvalid <= 1'b0;
      r_wvalid  <= 1'b0;
      r_bready  <= 1'b0;
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
      r_awaddr  <= '0;
      r_wdata   <= '0;
      r_wresp   <= OKAY;
    end else begin
      case (r_wstate)
        W_IDLE: begin
          if (AMCI_WRITE) begin
            r_awaddr  <= AMCI_WADDR;
            r_wdata   <= AMCI_WDATA;
            r_awvalid <= 1'b1;
`ifdef AXI4_LITE_MASTER_SERIAL_AW_W_EN
            r_wvalid  <= 1'b0;
`else
            r_wvalid  <= 1'b1;
`endif
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
            r_wstate  <= W_ADDR_DATA;
          end
        end
        W_ADDR_DATA: begin
          if (w_aw_hs) begin
            r_awvalid <= 1'b0;
            r_aw_done <= 1'b1;
`ifdef AXI4_LITE_MASTER_SERIAL_AW_W_EN
            r_wvalid  <= 1'b1;
`endif
          end
          if (w_w_hs) begin
            r_wvalid <= 1'b0;
            r_w_done <= 1'b1;
          end
          if (w_aw_fin && w_w_fin) begin
            r_bready <= 1'b1;
            r_wstate <= W_RESP;
          end
        end
        W_RESP: begin
          if (m_axi.M_AXI_BVALID) begin
            r_wresp  <= m_axi.M_AXI_BRESP;
            r_bready <= 1'b0;
            r_wstate <= W_IDLE;
          end
        end
        default: r_wstate <= W_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_rstate  <= R_IDLE;
      r_arvalid <= 1'b0;
      r_rready  <= 1'b0;
      r_araddr  <= '0;
      r_rdata   <= '0;
      r_rresp   <= OKAY;
    end else begin
      case (r_rstate)
        R_IDLE: begin
          if (AMCI_READ) begin
            r_araddr  <= AMCI_RADDR;
            r_arvalid <= 1'b1;
            r_rstate  <= R_ADDR;
          end
        end
        R_ADDR: begin
          if (m_axi.M_AXI_ARREADY) begin
            r_arvalid <= 1'b0;
            r_rready  <= 1'b1;
            r_rstate  <= R_DATA;
          end
        end
        R_DATA: begin
          if (m_axi.M_AXI_RVALID) begin
            r_rdata  <= m_axi.M_AXI_RDATA;
            r_rresp  <= m_axi.M_AXI_RRESP;
            r_rready <= 1'b0;
            r_rstate <= R_IDLE;
          end
        end
        default: r_rstate <= R_IDLE;
      endcase
    end
  end

  assign AMCI_WIDLE = (r_wstate == W_IDLE) && !AMCI_WRITE;
  assign AMCI_RIDLE = (r_rstate == R_IDLE) && !AMCI_READ;
  assign AMCI_WRESP = r_wresp;
  assign AMCI_RDATA = r_rdata;
  assign AMCI_RRESP = r_rresp;

  assign m_axi.M_AXI_AWADDR  = r_awaddr;
  assign m_axi.M_AXI_AWVALID = r_awvalid;
  assign m_axi.M_AXI_WDATA   = r_wdata;
  assign m_axi.M_AXI_WSTRB   = '1;
  assign m_axi.M_AXI_WVALID  = r_wvalid;
  assign m_axi.M_AXI_BREADY  = r_bready;
  assign m_axi.M_AXI_ARADDR  = r_araddr;
  assign m_axi.M_AXI_ARVALID = r_arvalid;
  assign m_axi.M_AXI_RREADY  = r_rready;

endmodule
